// File: rtl/dffsr_cell_tester_pkg.sv
// Shared types and the fixed vector table for the dffsr_cell built-in tester.
// Used by dffsr_cell_tester, its interface and the optional DSR_SYNC_EN synchronizer.
package dsr_test_pkg;

    localparam int NUM_STEPS   = 8;
    localparam int SYNC_STAGES = 2;
    localparam int STEP_W      = 3;
    localparam int CNT_W       = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_PULSE_HI,
        ST_PULSE_LO,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic d;
        logic s;
        logic r;
        logic clk;
        logic exp_q;
    } dsr_vec_t;

    // s and r are never both set; steps 5 and 6 check set/reset priority over the clock.
    localparam dsr_vec_t DSR_VECTORS [NUM_STEPS] = '{
        '{d: 1'b0, s: 1'b0, r: 1'b1, clk: 1'b0, exp_q: 1'b0},
        '{d: 1'b0, s: 1'b1, r: 1'b0, clk: 1'b0, exp_q: 1'b1},
        '{d: 1'b0, s: 1'b0, r: 1'b0, clk: 1'b1, exp_q: 1'b0},
        '{d: 1'b1, s: 1'b0, r: 1'b0, clk: 1'b1, exp_q: 1'b1},
        '{d: 1'b0, s: 1'b0, r: 1'b0, clk: 1'b0, exp_q: 1'b1},
        '{d: 1'b1, s: 1'b0, r: 1'b1, clk: 1'b1, exp_q: 1'b0},
        '{d: 1'b0, s: 1'b1, r: 1'b0, clk: 1'b1, exp_q: 1'b1},
        '{d: 1'b0, s: 1'b0, r: 1'b0, clk: 1'b1, exp_q: 1'b0}
    };

endpackage

// File: rtl/dffsr_cell_tester_if.sv
// Control/status and cell-pin bundle of the dffsr_cell tester.
// master = tester side, slave = the environment (cell + controller).
interface dffsr_cell_tester_if;
    import dsr_test_pkg::*;

    logic              start;
    logic              q_in;
    logic              notq_in;
    logic              dut_d;
    logic              dut_clk;
    logic              dut_s;
    logic              dut_r;
    logic              busy;
    logic              done;
    logic              pass;
    logic [STEP_W-1:0] fail_step;

    modport master (
        input  start, q_in, notq_in,
        output dut_d, dut_clk, dut_s, dut_r, busy, done, pass, fail_step
    );

    modport slave (
        output start, q_in, notq_in,
        input  dut_d, dut_clk, dut_s, dut_r, busy, done, pass, fail_step
    );
endinterface

// File: rtl/dffsr_cell_tester_sync2.sv
// Two-stage, 2-bit synchronizer for the cell's q/notq feedback.
// Only instantiated by dffsr_cell_tester when DSR_SYNC_EN is defined.
module dsr_sync2
    import dsr_test_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] din_i,
    output logic [1:0] dout_o
);

    logic [1:0] stage_q [SYNC_STAGES];

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        logic [1:0] stage_d;
        if (gi == 0) begin : g_first
            assign stage_d = din_i;
        end else begin : g_rest
            assign stage_d = stage_q[gi-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q[gi] <= '0;
            end else begin
                stage_q[gi] <= stage_d;
            end
        end
    end

    assign dout_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/dffsr_cell_tester.sv
// Plays the 8-step vector table into a dffsr_cell and checks q/notq after each step.
// Define DSR_SYNC_EN to resynchronize q/notq and stretch SAMPLE by two cycles.
module dffsr_cell_tester
    import dsr_test_pkg::*;
#(
    parameter int SETTLE_CYC = 2
)
(
    input  logic                 clk,
    input  logic                 rst,
    dffsr_cell_tester_if.master  tst
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    logic [1:0] cell_obs;   // {q, notq} as seen by the compare

`ifdef DSR_SYNC_EN
    localparam int SAMPLE_LEN = SETTLE_CYC + SYNC_STAGES;

    dsr_sync2 u_sync (
        .clk    (clk),
        .rst    (rst),
        .din_i  ({tst.q_in, tst.notq_in}),
        .dout_o (cell_obs)
    );
`else
    localparam int SAMPLE_LEN = SETTLE_CYC;

    assign cell_obs = {tst.q_in, tst.notq_in};
`endif

    localparam logic [CNT_W-1:0] APPLY_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_LEN - 1);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dut_d_q, dut_d_d;
    logic              dut_clk_q, dut_clk_d;
    logic              dut_s_q, dut_s_d;
    logic              dut_r_q, dut_r_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [STEP_W-1:0] fail_step_q, fail_step_d;
    logic              match;
    logic              idle_like;
    logic              drive;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            dut_d_q     <= 1'b0;
            dut_clk_q   <= 1'b0;
            dut_s_q     <= 1'b0;
            dut_r_q     <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_step_q <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            dut_d_q     <= dut_d_d;
            dut_clk_q   <= dut_clk_d;
            dut_s_q     <= dut_s_d;
            dut_r_q     <= dut_r_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_step_q <= fail_step_d;
        end
    end

    assign match = (cell_obs[1] == DSR_VECTORS[step_q].exp_q) &&
                   (cell_obs[0] == ~DSR_VECTORS[step_q].exp_q);
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q + CNT_W'(1);
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                cnt_d = '0;
                if (tst.start) begin
                    state_d = ST_APPLY;
                    step_d  = '0;
                end
            end
            ST_APPLY: begin
                if (cnt_q == APPLY_LAST) begin
                    cnt_d   = '0;
                    state_d = DSR_VECTORS[step_q].clk ? ST_PULSE_HI : ST_SAMPLE;
                end
            end
            ST_PULSE_HI: begin
                cnt_d   = '0;
                state_d = ST_PULSE_LO;
            end
            ST_PULSE_LO: begin
                cnt_d   = '0;
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    cnt_d = '0;
                    if (!match || step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_APPLY;
                        step_d  = step_q + STEP_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pins are registered from the next state so they change together with it.
    always_comb begin
        drive       = (state_d == ST_APPLY) || (state_d == ST_PULSE_HI) ||
                      (state_d == ST_PULSE_LO) || (state_d == ST_SAMPLE);
        dut_d_d     = drive && DSR_VECTORS[step_d].d;
        dut_s_d     = drive && DSR_VECTORS[step_d].s;
        dut_r_d     = drive && DSR_VECTORS[step_d].r;
        dut_clk_d   = (state_d == ST_PULSE_HI);
        done_d      = done_q;
        pass_d      = pass_q;
        fail_step_d = fail_step_q;
        if (idle_like && tst.start) begin
            done_d      = 1'b0;
            pass_d      = 1'b0;
            fail_step_d = '0;
        end
        if (state_q == ST_SAMPLE && state_d == ST_DONE) begin
            done_d      = 1'b1;
            pass_d      = match;
            fail_step_d = match ? '0 : step_q;
        end
    end

    assign tst.busy      = !idle_like;
    assign tst.done      = done_q;
    assign tst.pass      = pass_q;
    assign tst.fail_step = fail_step_q;
    assign tst.dut_d     = dut_d_q;
    assign tst.dut_clk   = dut_clk_q;
    assign tst.dut_s     = dut_s_q;
    assign tst.dut_r     = dut_r_q;

endmodule
